encoder_round_sched: RTL and testbench
======================================

ENCODER_ROUND_SCHED -- requirements
Module: encoder_round_sched

Interface
REQ-001 SHALL have parameter N_ROUNDS, default 24, number of encoder rounds per message.
REQ-002 SHALL have parameter N_STAGES, default 4, number of datapath stages per round (max 4).
REQ-003 SHALL have parameter TIMEOUT, default 256, cycles allowed for one stage to answer.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request one full encode; sampled only in IDLE or ERR.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current encode.
REQ-008 SHALL have port stage_done  input  1  one-cycle completion pulse from the selected stage.
REQ-009 SHALL have port stage_start  output  1  one-cycle launch pulse to the selected stage.
REQ-010 SHALL have port stage_sel  output  2  index of the active stage.
REQ-011 SHALL have port round_idx  output  5  current round number, feeds the round-constant lookup.
REQ-012 SHALL have port buf_sel  output  1  ping-pong buffer select; stage reads buf_sel, writes ~buf_sel.
REQ-013 SHALL have ports ready, busy, done, err  output  1 each  status (done is a one-cycle pulse).

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, FINISH, ERR.
REQ-015 IDLE: ready=1; start=1 SHALL clear stage_sel, round_idx, buf_sel and move to ISSUE next cycle.
REQ-016 ISSUE: stage_start=1 for exactly one cycle, watchdog cleared; SHALL move to WAIT unconditionally.
REQ-017 stage_done asserted during ISSUE or IDLE SHALL be ignored.
REQ-018 WAIT, stage_done=1: toggle buf_sel; if stage_sel<N_STAGES-1 increment stage_sel, else stage_sel=0 and round_idx+1; next state ISSUE.
REQ-019 WAIT, stage_done=1 with stage_sel=N_STAGES-1 and round_idx=N_ROUNDS-1: SHALL go to FINISH, counters held.
REQ-020 FINISH: done=1 for one cycle; SHALL return to IDLE next cycle.
REQ-021 WAIT: watchdog SHALL increment each cycle without stage_done; reaching TIMEOUT-1 SHALL enter ERR.
REQ-022 stage_done in the same cycle the watchdog reaches TIMEOUT-1 SHALL win (normal advance, no ERR).
REQ-023 ERR: err=1, ready=0; start=1 SHALL return to IDLE (no launch); other inputs ignored.
REQ-024 abort=1 in ISSUE, WAIT or FINISH SHALL force IDLE next cycle, no done pulse; abort has priority over stage_done and timeout.
REQ-025 busy SHALL be 1 exactly in ISSUE, WAIT, FINISH; ready SHALL be 1 only in IDLE.
REQ-026 Outputs SHALL be decoded from state/counters only (Moore); no combinational input-to-output path.
REQ-027 Total latency for an uninterrupted encode with stage response d cycles after stage_start SHALL be N_ROUNDS*N_STAGES*(d+1)+1 cycles from start sample to done.

Reset
REQ-028 rst low SHALL force IDLE asynchronously; stage_sel=0, round_idx=0, buf_sel=0, watchdog=0.
REQ-029 During reset outputs SHALL be ready=1, busy=0, stage_start=0, done=0, err=0.
REQ-030 Reset asserted mid-encode SHALL discard progress; no done pulse after release.

Structure
REQ-031 State encoding and default N_ROUNDS/N_STAGES/TIMEOUT SHALL live in shared package encoder_pkg.
REQ-032 Watchdog SHALL be a sub-module sched_watchdog (clear, enable, expired) sized clog2(TIMEOUT).
REQ-033 Round/stage counters and FSM SHALL stay in encoder_round_sched.

Verification
REQ-034 Nominal: N_ROUNDS=24, N_STAGES=4, stage model answers 3 cycles after stage_start -> 96 stage_start pulses, buf_sel toggles 96 times, done 385 cycles after start.
REQ-035 Sequence check: stage_sel 0,1,2,3 repeating; round_idx increments after each stage_sel=3 done, ends at 23.
REQ-036 Timeout: model never answers in round 5 stage 2 -> err=1 exactly TIMEOUT cycles after stage_start; start -> ready=1, err=0, no stage_start.
REQ-037 Race: stage_done on the cycle watchdog hits TIMEOUT-1 -> advance, err stays 0.
REQ-038 Abort at round 10 WAIT with simultaneous stage_done -> IDLE next cycle, round_idx reset by next start, no done.
REQ-039 rst low mid-round 7 -> immediate ready=1, busy=0; spurious stage_done after release -> ignored.

Source files
------------

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared state encoding and default sizing for the encoder round scheduler
package encoder_pkg;

    localparam int N_ROUNDS_DEF = 24;
    localparam int N_STAGES_DEF = 4;
    localparam int TIMEOUT_DEF  = 256;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

endpackage

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - per-stage response watchdog for the encoder round scheduler
module sched_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the cycle whose increment brings the count to TIMEOUT-1.
    assign expired = enable && (count == W'(TIMEOUT - 2));

endmodule

// File: rtl/encoder_round_sched.sv
// rtl/encoder_round_sched.sv - sequences N_ROUNDS x N_STAGES datapath stage launches per encode
module encoder_round_sched
    import encoder_pkg::*;
#(
    parameter int N_ROUNDS = N_ROUNDS_DEF,
    parameter int N_STAGES = N_STAGES_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       stage_done,
    output logic       stage_start,
    output logic [1:0] stage_sel,
    output logic [4:0] round_idx,
    output logic       buf_sel,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    logic [2:0] state;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;
    logic       last_stage;
    logic       last_round;

    assign last_stage = (stage_sel == 2'(N_STAGES - 1));
    assign last_round = (round_idx == 5'(N_ROUNDS - 1));

    assign wd_clear  = (state != S_WAIT);
    assign wd_enable = (state == S_WAIT) && !stage_done && !abort;

    sched_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            stage_sel <= '0;
            round_idx <= '0;
            buf_sel   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        stage_sel <= '0;
                        round_idx <= '0;
                        buf_sel   <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= abort ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // Abort beats a completing stage, which in turn beats the watchdog.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (stage_done) begin
                        buf_sel <= ~buf_sel;
                        if (!last_stage) begin
                            stage_sel <= stage_sel + 2'd1;
                            state     <= S_ISSUE;
                        end else if (!last_round) begin
                            stage_sel <= '0;
                            round_idx <= round_idx + 5'd1;
                            state     <= S_ISSUE;
                        end else begin
                            state <= S_FINISH;
                        end
                    end else if (wd_expired) begin
                        state <= S_ERR;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                S_ERR: begin
                    if (start) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign stage_start = (state == S_ISSUE);
    assign ready       = (state == S_IDLE);
    assign busy        = (state == S_ISSUE) || (state == S_WAIT) || (state == S_FINISH);
    assign done        = (state == S_FINISH);
    assign err         = (state == S_ERR);

endmodule

// File: tb/tb_encoder_round_sched.sv
// tb/tb_encoder_round_sched.sv - directed self-checking bench for encoder_round_sched
module tb_encoder_round_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stage_done = 1'b0;
    logic       stage_start;
    logic [1:0] stage_sel;
    logic [4:0] round_idx;
    logic       buf_sel;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pend     = 0;
    int d_resp   = 3;
    int mute_r   = -1;
    int mute_s   = -1;
    int mute_cyc = -1;
    int n_ss     = 0;
    int n_tog    = 0;
    int n_done   = 0;
    int seq_err  = 0;
    int exp_st   = 0;
    int exp_rd   = 0;
    logic prev_buf = 1'b0;

    encoder_round_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .stage_sel   (stage_sel),
        .round_idx   (round_idx),
        .buf_sel     (buf_sel),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: observe outputs at the falling edge and drive the stage model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        stage_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) stage_done = 1'b1;
        end
        if (stage_start) begin
            n_ss++;
            if (int'(stage_sel) != exp_st || int'(round_idx) != exp_rd) seq_err++;
            if (exp_st == 3) begin
                exp_st = 0;
                exp_rd++;
            end else begin
                exp_st++;
            end
            if (int'(round_idx) == mute_r && int'(stage_sel) == mute_s) mute_cyc = cyc;
            else pend = d_resp;
        end
        if (buf_sel !== prev_buf) n_tog++;
        prev_buf = buf_sel;
        if (done) n_done++;
    endtask

    task automatic begin_encode(output int s_cyc);
        n_ss = 0; seq_err = 0; n_done = 0; exp_st = 0; exp_rd = 0; pend = 0; mute_cyc = -1;
        tick();
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        n_tog = 0;
    endtask

    initial begin
        int s;
        int snap;
        bit hit;

        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_stage_start", stage_start, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Nominal encode, stage answers 3 cycles after launch
        d_resp = 3;
        begin_encode(s);
        for (int i = 0; i < 1000 && n_done == 0; i++) tick();
        check("nom_latency", cyc - s, 385);
        check("nom_launches", n_ss, 96);
        check("nom_toggles", n_tog, 96);
        check("nom_sequence", seq_err, 0);
        check("nom_round_end", round_idx, 23);
        check("nom_stage_end", stage_sel, 3);
        check("nom_finish_busy", busy, 1);
        tick();
        check("nom_post_ready", ready, 1);
        check("nom_post_done", done, 0);
        check("nom_buf_end", buf_sel, 0);

        // Timeout: round 5 stage 2 never answers
        mute_r = 5;
        mute_s = 2;
        begin_encode(s);
        for (int i = 0; i < 3000 && !err; i++) tick();
        check("to_latency", cyc - mute_cyc, 256);
        check("to_err", err, 1);
        check("to_ready", ready, 0);
        check("to_busy", busy, 0);
        mute_r = -1;
        mute_s = -1;
        tick();
        check("to_err_held", err, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_recover_ready", ready, 1);
        check("to_recover_err", err, 0);
        snap = n_ss;
        repeat (5) tick();
        check("to_no_launch", n_ss, snap);

        // Race: stage_done in the watchdog's final cycle
        d_resp = 255;
        begin_encode(s);
        for (int i = 0; i < 700 && n_ss < 2; i++) tick();
        check("race_err", err, 0);
        check("race_launches", n_ss, 2);
        check("race_stage", stage_sel, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pend = 0;
        check("race_abort_ready", ready, 1);

        // Abort at round 10 coincident with stage_done
        d_resp = 3;
        begin_encode(s);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            if (stage_done && round_idx == 5'd10 && stage_sel == 2'd1) hit = 1'b1;
        end
        check("ab_hit", hit, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pend = 0;
        check("ab_ready", ready, 1);
        check("ab_busy", busy, 0);
        check("ab_round_held", round_idx, 10);
        repeat (10) tick();
        check("ab_no_done", n_done, 0);
        begin_encode(s);
        check("ab_restart_round", round_idx, 0);
        check("ab_restart_stage", stage_sel, 0);
        check("ab_restart_launch", stage_start, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pend = 0;

        // Reset mid round 7
        begin_encode(s);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            if (round_idx == 5'd7 && stage_sel == 2'd2) hit = 1'b1;
        end
        check("rs_hit", hit, 1);
        rst = 1'b0;
        #1;
        check("rs_ready", ready, 1);
        check("rs_busy", busy, 0);
        check("rs_stage_start", stage_start, 0);
        check("rs_round", round_idx, 0);
        check("rs_buf", buf_sel, 0);
        pend = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        stage_done = 1'b1;
        snap = n_ss;
        n_done = 0;
        repeat (6) tick();
        check("rs_spurious_launch", n_ss, snap);
        check("rs_spurious_done", n_done, 0);
        check("rs_spurious_ready", ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
